// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_port_arbiter_if                                             |
// | Purpose  : Bundles the fetch, data and memory-bus handshakes of            |
// |            mem_port_arbiter into one interface.                            |
// | Modports : master - arbiter view (drives the memory bus, the completion    |
// |                     pulses, the read data and the stall requests)          |
// |            slave  - environment view (pipeline stages plus memory)         |
// | Signals  : if_req/if_addr/if_kill -> if_rdata/if_ready    fetch port       |
// |            dm_req/we/be/addr/wdata -> dm_rdata/dm_ready   data port        |
// |            bus_req/we/be/addr/wdata <- bus_rdata/bus_ack  memory bus       |
// |            stall_if, stall_mem                            hazard requests  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // Fetch port
    logic              if_req;
    logic [AW-1:0]     if_addr;
    logic              if_kill;
    logic [DW-1:0]     if_rdata;
    logic              if_ready;
    // Data port
    logic              dm_req;
    logic              dm_we;
    logic [DW/8-1:0]   dm_be;
    logic [AW-1:0]     dm_addr;
    logic [DW-1:0]     dm_wdata;
    logic [DW-1:0]     dm_rdata;
    logic              dm_ready;
    // Memory bus
    logic              bus_req;
    logic              bus_we;
    logic [DW/8-1:0]   bus_be;
    logic [AW-1:0]     bus_addr;
    logic [DW-1:0]     bus_wdata;
    logic [DW-1:0]     bus_rdata;
    logic              bus_ack;
    // Hazard-unit stall requests
    logic              stall_if;
    logic              stall_mem;

    modport master (
        input  if_req, if_addr, if_kill,
        output if_rdata, if_ready,
        input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
        output dm_rdata, dm_ready,
        output bus_req, bus_we, bus_be, bus_addr, bus_wdata,
        input  bus_rdata, bus_ack,
        output stall_if, stall_mem
    );

    modport slave (
        output if_req, if_addr, if_kill,
        input  if_rdata, if_ready,
        output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
        input  dm_rdata, dm_ready,
        input  bus_req, bus_we, bus_be, bus_addr, bus_wdata,
        output bus_rdata, bus_ack,
        input  stall_if, stall_mem
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_port_arbiter                                                |
// | Purpose  : Shares one single-ported memory bus between the fetch (IF) and  |
// |            load/store (MEM) stages. Transactions are serialised, the      |
// |            losing stage is held through stall_if / stall_mem and read     |
// |            data is returned with a one-cycle ready pulse.                  |
// | Ports    : clk     - rising-edge clock                                     |
// |            rst_n   - asynchronous active-low reset                         |
// |            mp      - mem_port_arbiter_if.master (fetch, data, bus, stalls) |
// | Params   : AW, DW        - address / data width (must match mp)            |
// |            MAX_DM_BURST  - data grants allowed while fetch waits           |
// | Options  : ARB_FETCH_FAIR_EN - when defined, a saturating counter lets a   |
// |            waiting fetch win after MAX_DM_BURST data grants; otherwise     |
// |            data always has priority.                                       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mem_port_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int MAX_DM_BURST = 4
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    mem_port_arbiter_if.master  mp
);

    localparam int BW = DW / 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_IF_BUSY = 2'd1,
        ST_DM_BUSY = 2'd2
    } state_t;

    state_t             state_q;
    logic               bus_req_q;
    logic               bus_we_q;
    logic [BW-1:0]      bus_be_q;
    logic [AW-1:0]      bus_addr_q;
    logic [DW-1:0]      bus_wdata_q;
    logic               if_ready_q;
    logic               dm_ready_q;
    logic [DW-1:0]      if_rdata_q;
    logic [DW-1:0]      dm_rdata_q;
    logic               kill_q;

    logic               w_if_elig;
    logic               w_dm_elig;
    logic               w_grant_if;
    logic               w_grant_dm;
    logic               w_kill;

    // A requester whose ready pulse is showing still holds req for the
    // transaction just finished, so it must not be granted again that cycle.
    assign w_if_elig = mp.if_req & ~if_ready_q;
    assign w_dm_elig = mp.dm_req & ~dm_ready_q;

`ifdef ARB_FETCH_FAIR_EN
    localparam int CNT_W = $clog2(MAX_DM_BURST + 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(MAX_DM_BURST);

    logic [CNT_W-1:0]   burst_q;
    logic [CNT_W-1:0]   burst_d;

    // Fetch overrides data once the data side has used up its burst allowance.
    assign w_grant_if = w_if_elig & (~w_dm_elig | (burst_q == C_CNT_MAX));

    always_comb begin
        burst_d = burst_q;
        if (state_q == ST_IDLE) begin
            if (w_grant_if || !mp.if_req) begin
                burst_d = '0;
            end else if (w_grant_dm && (burst_q != C_CNT_MAX)) begin
                burst_d = burst_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_q <= '0;
        end else begin
            burst_q <= burst_d;
        end
    end
`else
    assign w_grant_if = w_if_elig & ~w_dm_elig;
`endif

    assign w_grant_dm = w_dm_elig & ~w_grant_if;

    // Kill seen earlier in the transaction or in the ack cycle itself.
    assign w_kill = kill_q | mp.if_kill;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_be_q    <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            if_ready_q  <= 1'b0;
            dm_ready_q  <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            kill_q      <= 1'b0;
        end else begin
            // Ready outputs are single-cycle pulses.
            if_ready_q <= 1'b0;
            dm_ready_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    kill_q <= 1'b0;
                    if (w_grant_if) begin
                        state_q     <= ST_IF_BUSY;
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= 1'b0;
                        bus_be_q    <= '1;
                        bus_addr_q  <= mp.if_addr;
                        bus_wdata_q <= '0;
                    end else if (w_grant_dm) begin
                        state_q     <= ST_DM_BUSY;
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= mp.dm_we;
                        bus_be_q    <= mp.dm_be;
                        bus_addr_q  <= mp.dm_addr;
                        bus_wdata_q <= mp.dm_wdata;
                    end
                end
                ST_IF_BUSY: begin
                    if (mp.bus_ack) begin
                        // A squashed fetch still finishes on the bus but is
                        // never reported back to the pipeline.
                        if (!w_kill) begin
                            if_rdata_q <= mp.bus_rdata;
                            if_ready_q <= 1'b1;
                        end
                        bus_req_q <= 1'b0;
                        kill_q    <= 1'b0;
                        state_q   <= ST_IDLE;
                    end else if (mp.if_kill) begin
                        kill_q <= 1'b1;
                    end
                end
                ST_DM_BUSY: begin
                    if (mp.bus_ack) begin
                        dm_rdata_q <= mp.bus_rdata;
                        dm_ready_q <= 1'b1;
                        bus_req_q  <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end
                default: begin
                    bus_req_q <= 1'b0;
                    kill_q    <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign mp.bus_req   = bus_req_q;
    assign mp.bus_we    = bus_we_q;
    assign mp.bus_be    = bus_be_q;
    assign mp.bus_addr  = bus_addr_q;
    assign mp.bus_wdata = bus_wdata_q;
    assign mp.if_ready  = if_ready_q;
    assign mp.if_rdata  = if_rdata_q;
    assign mp.dm_ready  = dm_ready_q;
    assign mp.dm_rdata  = dm_rdata_q;

    assign mp.stall_if  = mp.if_req & ~if_ready_q;
    assign mp.stall_mem = mp.dm_req & ~dm_ready_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mem_port_arbiter                                             |
// | Purpose  : Self-checking bench for mem_port_arbiter: reset behaviour,      |
// |            a table of single transactions, hand-written collision / kill  |
// |            / stray-ack sequences and a randomized run against a           |
// |            transaction-level reference model.                              |
// | Options  : ARB_FETCH_FAIR_EN selects the fairness rule in the model.       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_mem_port_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXB = 4;
    localparam int N_RANDOM = 3000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) mpif ();

    mem_port_arbiter #(
        .AW           (AW),
        .DW           (DW),
        .MAX_DM_BURST (MAXB)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mp    (mpif)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        mpif.if_req    = 1'b0;
        mpif.if_addr   = '0;
        mpif.if_kill   = 1'b0;
        mpif.dm_req    = 1'b0;
        mpif.dm_we     = 1'b0;
        mpif.dm_be     = '0;
        mpif.dm_addr   = '0;
        mpif.dm_wdata  = '0;
        mpif.bus_rdata = '0;
        mpif.bus_ack   = 1'b0;
    endtask

    task automatic chk_all_regs_zero(input string tag);
        chk({tag, "_bus_req"},   64'(mpif.bus_req),   64'd0);
        chk({tag, "_bus_we"},    64'(mpif.bus_we),    64'd0);
        chk({tag, "_bus_be"},    64'(mpif.bus_be),    64'd0);
        chk({tag, "_bus_addr"},  64'(mpif.bus_addr),  64'd0);
        chk({tag, "_bus_wdata"}, 64'(mpif.bus_wdata), 64'd0);
        chk({tag, "_if_ready"},  64'(mpif.if_ready),  64'd0);
        chk({tag, "_dm_ready"},  64'(mpif.dm_ready),  64'd0);
        chk({tag, "_if_rdata"},  64'(mpif.if_rdata),  64'd0);
        chk({tag, "_dm_rdata"},  64'(mpif.dm_rdata),  64'd0);
    endtask

    // ------------------------------------------------------------------
    // Single-transaction vectors
    // ------------------------------------------------------------------
    typedef struct {
        bit          is_dm;
        bit          we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;     // bus_req cycles until ack (>=1)
        bit          exp_we;
        logic [3:0]  exp_be;
        logic [31:0] exp_rdata;
    } vec_t;

    function automatic vec_t mk(bit is_dm, bit we, logic [3:0] be, logic [31:0] addr,
                                logic [31:0] wdata, logic [31:0] rdata, int delay,
                                bit exp_we, logic [3:0] exp_be, logic [31:0] exp_rdata);
        vec_t v;
        v.is_dm = is_dm; v.we = we; v.be = be; v.addr = addr; v.wdata = wdata;
        v.rdata = rdata; v.delay = delay; v.exp_we = exp_we; v.exp_be = exp_be;
        v.exp_rdata = exp_rdata;
        return v;
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        string t;
        t = $sformatf("vec%0d", idx);
        if (v.is_dm) begin
            mpif.dm_req = 1'b1; mpif.dm_we = v.we; mpif.dm_be = v.be;
            mpif.dm_addr = v.addr; mpif.dm_wdata = v.wdata;
        end else begin
            mpif.if_req = 1'b1; mpif.if_addr = v.addr;
            mpif.dm_be = v.be;  // fetch must ignore data-side byte enables
        end
        #1;
        chk({t, "_stall_req"}, 64'(v.is_dm ? mpif.stall_mem : mpif.stall_if), 64'd1);
        tick();
        chk({t, "_bus_req"},  64'(mpif.bus_req),  64'd1);
        chk({t, "_bus_we"},   64'(mpif.bus_we),   64'(v.exp_we));
        chk({t, "_bus_be"},   64'(mpif.bus_be),   64'(v.exp_be));
        chk({t, "_bus_addr"}, 64'(mpif.bus_addr), 64'(v.addr));
        if (v.is_dm && v.we) chk({t, "_bus_wdata"}, 64'(mpif.bus_wdata), 64'(v.wdata));
        for (int i = 1; i < v.delay; i++) begin
            tick();
            chk({t, "_hold_req"},  64'(mpif.bus_req),  64'd1);
            chk({t, "_hold_addr"}, 64'(mpif.bus_addr), 64'(v.addr));
            chk({t, "_hold_be"},   64'(mpif.bus_be),   64'(v.exp_be));
            chk({t, "_no_ready"},  64'(mpif.if_ready | mpif.dm_ready), 64'd0);
        end
        mpif.bus_ack = 1'b1; mpif.bus_rdata = v.rdata;
        tick();
        mpif.bus_ack = 1'b0; mpif.bus_rdata = '0;
        chk({t, "_ready"},   64'(v.is_dm ? mpif.dm_ready : mpif.if_ready), 64'd1);
        chk({t, "_other_ready"}, 64'(v.is_dm ? mpif.if_ready : mpif.dm_ready), 64'd0);
        chk({t, "_rdata"},   64'(v.is_dm ? mpif.dm_rdata : mpif.if_rdata), 64'(v.exp_rdata));
        chk({t, "_req_drop"}, 64'(mpif.bus_req), 64'd0);
        mpif.if_req = 1'b0; mpif.dm_req = 1'b0;
        #1;
        chk({t, "_stall_off"}, 64'(mpif.stall_if | mpif.stall_mem), 64'd0);
        tick();
        chk({t, "_pulse_end"}, 64'(mpif.if_ready | mpif.dm_ready), 64'd0);
        chk({t, "_idle_req"},  64'(mpif.bus_req), 64'd0);
    endtask

    // ------------------------------------------------------------------
    // Reference model: one transaction owner at a time, tracked in plain
    // variables and advanced once per clock from the arbitration rules.
    // ------------------------------------------------------------------
    typedef struct {
        int          owner;     // 0 none, 1 fetch, 2 data
        bit          breq;
        bit          bwe;
        logic [3:0]  bbe;
        logic [31:0] baddr;
        logic [31:0] bwdata;
        logic [31:0] ifd;
        logic [31:0] dmd;
        bit          ifr;
        bit          dmr;
        bit          kill;
        int          cnt;
    } model_t;

    function automatic model_t model_reset();
        model_t m;
        m.owner = 0; m.breq = 0; m.bwe = 0; m.bbe = '0; m.baddr = '0; m.bwdata = '0;
        m.ifd = '0; m.dmd = '0; m.ifr = 0; m.dmr = 0; m.kill = 0; m.cnt = 0;
        return m;
    endfunction

    function automatic model_t model_step(model_t m);
        model_t n;
        bit fe, de, fair, k;
        n = m;
        n.ifr = 0;
        n.dmr = 0;
        fair = 0;
        if (m.owner == 0) begin
            fe = mpif.if_req && !m.ifr;
            de = mpif.dm_req && !m.dmr;
`ifdef ARB_FETCH_FAIR_EN
            fair = (m.cnt == MAXB);
`endif
            n.kill = 0;
            if (fe && (!de || fair)) begin
                n.owner = 1; n.breq = 1; n.bwe = 0; n.bbe = 4'hF;
                n.baddr = mpif.if_addr; n.bwdata = '0; n.cnt = 0;
            end else if (de) begin
                n.owner = 2; n.breq = 1; n.bwe = mpif.dm_we; n.bbe = mpif.dm_be;
                n.baddr = mpif.dm_addr; n.bwdata = mpif.dm_wdata;
                n.cnt = mpif.if_req ? ((m.cnt < MAXB) ? m.cnt + 1 : MAXB) : 0;
            end else if (!mpif.if_req) begin
                n.cnt = 0;
            end
        end else begin
            k = m.kill || (m.owner == 1 && mpif.if_kill);
            if (mpif.bus_ack) begin
                n.owner = 0; n.breq = 0; n.kill = 0;
                if (m.owner == 2) begin
                    n.dmd = mpif.bus_rdata; n.dmr = 1;
                end else if (!k) begin
                    n.ifd = mpif.bus_rdata; n.ifr = 1;
                end
            end else begin
                n.kill = k;
            end
        end
        return n;
    endfunction

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    vec_t   vt [5];
    model_t m;

    initial begin
        vt[0] = mk(1'b0, 1'b0, 4'h0, 32'h0000_0100, 32'h0,         32'h0000_0013, 1, 1'b0, 4'hF, 32'h0000_0013);
        vt[1] = mk(1'b1, 1'b0, 4'hF, 32'h0000_2000, 32'h0,         32'hDEAD_BEEF, 2, 1'b0, 4'hF, 32'hDEAD_BEEF);
        vt[2] = mk(1'b1, 1'b1, 4'h3, 32'h0000_2004, 32'h0000_ABCD, 32'h1234_5678, 3, 1'b1, 4'h3, 32'h1234_5678);
        vt[3] = mk(1'b0, 1'b0, 4'h5, 32'h0000_0104, 32'h0,         32'h0050_0093, 4, 1'b0, 4'hF, 32'h0050_0093);
        vt[4] = mk(1'b1, 1'b1, 4'h8, 32'h0000_3000, 32'h1122_3344, 32'h0,         1, 1'b1, 4'h8, 32'h0);

        idle_inputs();
        @(negedge clk);

        // Reset held with requests and ack active
        rst_n = 1'b0;
        mpif.if_req = 1'b1; mpif.if_addr = 32'h0000_0100;
        mpif.dm_req = 1'b1; mpif.dm_we = 1'b1; mpif.dm_be = 4'hF;
        mpif.dm_addr = 32'h0000_2000; mpif.dm_wdata = 32'hFFFF_FFFF;
        mpif.bus_ack = 1'b1; mpif.bus_rdata = 32'hFFFF_FFFF;
        repeat (3) tick();
        chk_all_regs_zero("rst_hold");
        idle_inputs();
        rst_n = 1'b1;
        tick();

        // Reset asserted in the middle of a data transaction
        mpif.dm_req = 1'b1; mpif.dm_be = 4'hF; mpif.dm_addr = 32'h0000_0040;
        tick();
        chk("rst_mid_grant", 64'(mpif.bus_req), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_async_req", 64'(mpif.bus_req),  64'd0);
        chk("rst_mid_async_addr", 64'(mpif.bus_addr), 64'd0);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rst_mid_idle", 64'(mpif.bus_req), 64'd0);

        // Table of single transactions
        for (int i = 0; i < 5; i++) run_vec(i, vt[i]);

        // Collision: data load wins, fetch served afterwards
        mpif.if_req = 1'b1; mpif.if_addr = 32'h0000_0100;
        mpif.dm_req = 1'b1; mpif.dm_we = 1'b0; mpif.dm_be = 4'hF; mpif.dm_addr = 32'h0000_2000;
        tick();
        chk("col_dm_addr", 64'(mpif.bus_addr), 64'h2000);
        chk("col_dm_we",   64'(mpif.bus_we),   64'd0);
        chk("col_stall_if_busy", 64'(mpif.stall_if), 64'd1);
        mpif.bus_ack = 1'b1; mpif.bus_rdata = 32'h0000_0055;
        tick();
        chk("col_dm_ready", 64'(mpif.dm_ready), 64'd1);
        chk("col_dm_rdata", 64'(mpif.dm_rdata), 64'h55);
        chk("col_stall_if_ready_cycle", 64'(mpif.stall_if), 64'd1);
        mpif.dm_req = 1'b0; mpif.bus_ack = 1'b0;
        tick();
        chk("col_if_req",  64'(mpif.bus_req),  64'd1);
        chk("col_if_addr", 64'(mpif.bus_addr), 64'h100);
        chk("col_if_be",   64'(mpif.bus_be),   64'hF);
        mpif.bus_ack = 1'b1; mpif.bus_rdata = 32'h0000_0013;
        tick();
        chk("col_if_ready", 64'(mpif.if_ready), 64'd1);
        chk("col_if_rdata", 64'(mpif.if_rdata), 64'h13);
        idle_inputs();
        tick();

        // Kill during IF_BUSY with a 3-cycle ack
        mpif.if_req = 1'b1; mpif.if_addr = 32'h0000_0200;
        tick();
        chk("kill_addr", 64'(mpif.bus_addr), 64'h200);
        mpif.if_kill = 1'b1;
        tick();
        mpif.if_kill = 1'b0;
        tick();
        mpif.bus_ack = 1'b1; mpif.bus_rdata = 32'h0000_0099;
        tick();
        chk("kill_no_ready", 64'(mpif.if_ready), 64'd0);
        chk("kill_rdata_kept", 64'(mpif.if_rdata), 64'h13);
        chk("kill_bus_done", 64'(mpif.bus_req), 64'd0);
        idle_inputs();
        tick();
        chk("kill_after", 64'(mpif.if_ready | mpif.bus_req), 64'd0);

        // Kill asserted only in the ack cycle
        mpif.if_req = 1'b1; mpif.if_addr = 32'h0000_0300;
        tick();
        mpif.if_kill = 1'b1; mpif.bus_ack = 1'b1; mpif.bus_rdata = 32'h0000_0077;
        tick();
        chk("killack_no_ready", 64'(mpif.if_ready), 64'd0);
        chk("killack_rdata_kept", 64'(mpif.if_rdata), 64'h13);
        idle_inputs();
        tick();

        // Kill while idle has no effect on the next fetch
        mpif.if_req = 1'b1; mpif.if_addr = 32'h0000_0400; mpif.if_kill = 1'b1;
        tick();
        mpif.if_kill = 1'b0;
        chk("idlekill_grant", 64'(mpif.bus_addr), 64'h400);
        mpif.bus_ack = 1'b1; mpif.bus_rdata = 32'h0000_0044;
        tick();
        chk("idlekill_ready", 64'(mpif.if_ready), 64'd1);
        chk("idlekill_rdata", 64'(mpif.if_rdata), 64'h44);
        idle_inputs();
        tick();

        // Stray ack while idle is ignored
        mpif.bus_ack = 1'b1; mpif.bus_rdata = 32'hCAFE_F00D;
        repeat (2) begin
            tick();
            chk("stray_ack_ready", 64'(mpif.if_ready | mpif.dm_ready), 64'd0);
            chk("stray_ack_req",   64'(mpif.bus_req), 64'd0);
        end
        chk("stray_ack_if_rdata", 64'(mpif.if_rdata), 64'h44);
        idle_inputs();

        // Randomized run against the reference model
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m = model_reset();
        for (int cyc = 0; cyc < N_RANDOM; cyc++) begin
            chk("rnd_bus_req",   64'(mpif.bus_req),   64'(m.breq));
            chk("rnd_bus_we",    64'(mpif.bus_we),    64'(m.bwe));
            chk("rnd_bus_be",    64'(mpif.bus_be),    64'(m.bbe));
            chk("rnd_bus_addr",  64'(mpif.bus_addr),  64'(m.baddr));
            chk("rnd_bus_wdata", 64'(mpif.bus_wdata), 64'(m.bwdata));
            chk("rnd_if_ready",  64'(mpif.if_ready),  64'(m.ifr));
            chk("rnd_dm_ready",  64'(mpif.dm_ready),  64'(m.dmr));
            chk("rnd_if_rdata",  64'(mpif.if_rdata),  64'(m.ifd));
            chk("rnd_dm_rdata",  64'(mpif.dm_rdata),  64'(m.dmd));

            if (m.ifr || !mpif.if_req) begin
                mpif.if_req  = ($urandom_range(99) < 45);
                mpif.if_addr = $urandom() & 32'hFFFF_FFFC;
            end
            mpif.if_kill = mpif.if_req && ($urandom_range(99) < 6);
            if (mpif.if_kill) mpif.if_addr = $urandom() & 32'hFFFF_FFFC;
            if (m.dmr || !mpif.dm_req) begin
                mpif.dm_req   = ($urandom_range(99) < 50);
                mpif.dm_we    = $urandom_range(1);
                mpif.dm_be    = 4'($urandom_range(15));
                mpif.dm_addr  = $urandom();
                mpif.dm_wdata = $urandom();
            end
            mpif.bus_ack   = m.breq ? ($urandom_range(99) < 45) : ($urandom_range(99) < 10);
            mpif.bus_rdata = $urandom();
            #1;
            chk("rnd_stall_if",  64'(mpif.stall_if),  64'(mpif.if_req && !m.ifr));
            chk("rnd_stall_mem", 64'(mpif.stall_mem), 64'(mpif.dm_req && !m.dmr));
            m = model_step(m);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
